// File: rtl/inst_queue_mw.sv
// rtl/inst_queue_mw.sv - multi-width instruction queue between IF and the ID issue decoder
// Accepts up to ENQ_W entries per cycle and presents the DEQ_W oldest entries to issue.
module inst_queue_mw #(
  parameter int DEPTH  = 16,
  parameter int ENQ_W  = 4,
  parameter int DEQ_W  = 2,
  parameter int DATA_W = 128,
  parameter int GAP    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          enq_valid_i,
  input  logic [ENQ_W-1:0]              enq_mask_i,
  input  logic [ENQ_W*DATA_W-1:0]       enq_data_i,
  output logic                          enq_ready_o,
  input  logic [$clog2(DEQ_W+1)-1:0]    deq_count_i,
  output logic [DEQ_W-1:0]              deq_valid_o,
  output logic [DEQ_W*DATA_W-1:0]       deq_data_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic                          stop_fetch_o,
  output logic                          err_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int SW = $clog2(ENQ_W + 1);

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]         count, free, deq_req, n_deq;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic [SW-1:0]         run_start, run_len, n_enq;
  logic [ENQ_W-1:0]      mask_sh;
  logic                  found, stop, mask_thermo;
  logic [ENQ_W*DATA_W-1:0] enq_shift;

  assign count        = tail_q - head_q;
  assign free         = PW'(DEPTH) - count;
  assign enq_ready_o  = (free >= PW'(ENQ_W));
  assign stop_fetch_o = (free < PW'(ENQ_W + GAP));
  assign count_o      = count;
  assign empty_o      = (count == '0);
  assign full_o       = (count == PW'(DEPTH));
  assign err_o        = err_q;

  // An illegal mask is reduced to its lowest contiguous run of ones, packed down to lane 0.
  always_comb begin
    run_start = '0;
    found     = 1'b0;
    for (int i = 0; i < ENQ_W; i++) begin
      if (!found && enq_mask_i[i]) begin
        found     = 1'b1;
        run_start = SW'(i);
      end
    end
    mask_sh = enq_mask_i >> run_start;
    run_len = '0;
    stop    = 1'b0;
    for (int i = 0; i < ENQ_W; i++) begin
      if (!stop && mask_sh[i]) run_len = run_len + 1'b1;
      else                     stop    = 1'b1;
    end
    mask_thermo = ((enq_mask_i & (enq_mask_i + 1'b1)) == '0);
    enq_shift   = enq_data_i >> (int'(run_start) * DATA_W);
  end

  assign n_enq   = (enq_valid_i && enq_ready_o) ? run_len : '0;
  assign deq_req = PW'(deq_count_i);
  assign n_deq   = (deq_req > count) ? count : deq_req;

  always_comb begin
    head_d = head_q + n_deq;
    tail_d = tail_q + PW'(n_enq);
    err_d  = err_q
           | (enq_valid_i && (|enq_mask_i) && !enq_ready_o)
           | (enq_valid_i && !mask_thermo)
           | (deq_req > count);
    // Errors still judge the pre-flush state; flush only resets the pointers.
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (SW'(i) < n_enq)
          mem_q[tail_q[IW-1:0] + IW'(i)] <= enq_shift[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    deq_valid_o = '0;
    deq_data_o  = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      deq_valid_o[j] = (count > PW'(j));
      if (deq_valid_o[j])
        deq_data_o[j*DATA_W +: DATA_W] = mem_q[head_q[IW-1:0] + IW'(j)];
    end
  end

endmodule

// File: tb/tb_inst_queue_mw.sv
// tb/tb_inst_queue_mw.sv - randomized self-checking bench for inst_queue_mw
// Reference model is a plain queue of entries plus a sticky error bit.
module tb_inst_queue_mw;

  localparam int DEPTH = 16, ENQ_W = 4, DEQ_W = 2, DATA_W = 128, GAP = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush_i;
  logic                      enq_valid_i;
  logic [ENQ_W-1:0]          enq_mask_i;
  logic [ENQ_W*DATA_W-1:0]   enq_data_i;
  logic                      enq_ready_o;
  logic [1:0]                deq_count_i;
  logic [DEQ_W-1:0]          deq_valid_o;
  logic [DEQ_W*DATA_W-1:0]   deq_data_o;
  logic [4:0]                count_o;
  logic                      empty_o, full_o, stop_fetch_o, err_o;

  inst_queue_mw #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .enq_valid_i(enq_valid_i),
    .enq_mask_i(enq_mask_i), .enq_data_i(enq_data_i), .enq_ready_o(enq_ready_o),
    .deq_count_i(deq_count_i), .deq_valid_o(deq_valid_o), .deq_data_o(deq_data_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .stop_fetch_o(stop_fetch_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [DATA_W-1:0] mq[$];
  bit m_err;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit is_thermo(input logic [3:0] m);
    for (int k = 0; k <= ENQ_W; k++)
      if (m == 4'((1 << k) - 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    int sz = mq.size();
    int fr = DEPTH - sz;
    check("count", DATA_W'(count_o), DATA_W'(sz));
    check("empty", DATA_W'(empty_o), DATA_W'(sz == 0));
    check("full", DATA_W'(full_o), DATA_W'(sz == DEPTH));
    check("enq_ready", DATA_W'(enq_ready_o), DATA_W'(fr >= ENQ_W));
    check("stop_fetch", DATA_W'(stop_fetch_o), DATA_W'(fr < ENQ_W + GAP));
    check("err", DATA_W'(err_o), DATA_W'(m_err));
    for (int j = 0; j < DEQ_W; j++) begin
      check($sformatf("valid%0d", j), DATA_W'(deq_valid_o[j]), DATA_W'(j < sz));
      check($sformatf("lane%0d", j), deq_data_o[j*DATA_W +: DATA_W], (j < sz) ? mq[j] : '0);
    end
  endtask

  task automatic model_step();
    int cnt = mq.size();
    bit rdy = (DEPTH - cnt) >= ENQ_W;
    int nd, st;
    if (enq_valid_i && enq_mask_i != 0 && !rdy) m_err = 1'b1;
    if (enq_valid_i && !is_thermo(enq_mask_i)) m_err = 1'b1;
    if (int'(deq_count_i) > cnt) m_err = 1'b1;
    if (flush_i) begin
      mq.delete();
    end else begin
      nd = (int'(deq_count_i) < cnt) ? int'(deq_count_i) : cnt;
      repeat (nd) void'(mq.pop_front());
      if (enq_valid_i && rdy) begin
        st = 0;
        while (st < ENQ_W && !enq_mask_i[st]) st++;
        while (st < ENQ_W && enq_mask_i[st]) begin
          mq.push_back(enq_data_i[st*DATA_W +: DATA_W]);
          st++;
        end
      end
    end
  endtask

  task automatic cyc(input logic fl, input logic v, input logic [3:0] m, input logic [1:0] d);
    flush_i = fl; enq_valid_i = v; enq_mask_i = m; deq_count_i = d;
    for (int i = 0; i < ENQ_W * DATA_W / 32; i++) enq_data_i[i*32 +: 32] = $urandom();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Called 1 time unit after a rising edge: asserts, checks, and releases before the next edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    mq.delete();
    m_err = 1'b0;
    check_all();
    #2 rst = 1'b1;
  endtask

  initial begin
    logic [3:0] m;
    rst = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0; enq_mask_i = '0;
    enq_data_i = '0; deq_count_i = '0; m_err = 1'b0;
    #1 check_all();
    #12 rst = 1'b1;

    cyc(0, 1, 4'b0111, 0);
    cyc(0, 0, 4'b0000, 2);
    cyc(0, 0, 4'b0000, 1);

    repeat (5) cyc(0, 1, 4'b1111, 0);
    do_reset();

    cyc(0, 1, 4'b1111, 0);
    for (int c = 0; c < 24; c++) cyc(0, (c % 2) == 0, 4'b1111, 2);
    while (mq.size() > 0) cyc(0, 0, 4'b0000, (mq.size() >= 2) ? 2'd2 : 2'd1);
    cyc(0, 1, 4'b1111, 0);
    cyc(0, 1, 4'b0001, 0);
    cyc(1, 1, 4'b1111, 2);

    cyc(0, 1, 4'b0001, 0);
    cyc(0, 0, 4'b0000, 2);
    do_reset();
    cyc(0, 1, 4'b0101, 0);
    do_reset();

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) m = 4'($urandom());
      else m = 4'((1 << $urandom_range(0, 4)) - 1);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, m, 2'($urandom_range(0, 2)));
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
